// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory bus.
// Holds the controller state encoding and the default memory map and
// timeout so the data memory and its initiator agree on one layout.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int          DEF_DEPTH     = 64;
  localparam int          DEF_TIMEOUT   = 15;

endpackage

// File: rtl/mem_wait_counter.sv
// Bus wait counter for the MEM-stage initiator.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count back to zero (has priority over en)
//   en       : advance the count by one this cycle
//   tc       : terminal count, high while the count equals LIMIT-1
module mem_wait_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage bus initiator: turns the EX/MEM load/store request into a
// req/ack transaction on the data-memory bus, stalls the pipeline while the
// transaction is open, and reports load data or an access error.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   Mem_R_EN, Mem_W_EN  : load / store requested by the instruction in MEM
//   ALU_Res, Val_Rm     : byte address, store data
//   freeze              : pipeline stall (combinational)
//   Data, data_valid    : load result and its one-cycle update pulse
//   mem_err             : one-cycle pulse for a rejected or timed-out access
//   bus_req, bus_we, bus_addr, bus_wdata : initiator side of the bus
//   bus_ack, bus_rdata  : responder completion pulse and read data
module mem_access_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int          AW        = 6,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Mem_R_EN,
  input  logic          Mem_W_EN,
  input  logic [31:0]   ALU_Res,
  input  logic [31:0]   Val_Rm,
  output logic          freeze,
  output logic [31:0]   Data,
  output logic          data_valid,
  output logic          mem_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t  state;
  logic        op;
  logic        legal;
  logic [31:0] off;
  logic [31:0] idx;
  logic        wait_tc;

  assign op  = Mem_R_EN | Mem_W_EN;
  // Subtraction wraps, so addresses below BASE_ADDR become huge and fail
  // the range test without a separate lower-bound compare.
  assign off = ALU_Res - BASE_ADDR;
  assign idx = {2'b00, off[31:2]};
  assign legal = (off[1:0] == 2'b00) && (idx < 32'(DEPTH)) && !(Mem_R_EN && Mem_W_EN);

  // The stall covers the request cycle itself and every bus cycle; DONE
  // releases it so the pipeline moves the instruction on exactly once.
  assign freeze = ((state == IDLE) && op) || (state == BUS);

  mem_wait_counter #(
    .W     (CW),
    .LIMIT (TIMEOUT)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (state != BUS),
    .en  (state == BUS),
    .tc  (wait_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      Data       <= '0;
      data_valid <= 1'b0;
      mem_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      data_valid <= 1'b0;
      mem_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (op) begin
            if (legal) begin
              bus_req   <= 1'b1;
              bus_we    <= Mem_W_EN;
              bus_addr  <= idx[AW-1:0];
              bus_wdata <= Val_Rm;
              state     <= BUS;
            end else begin
              // Rejected access: no bus cycle, error reported in DONE.
              mem_err <= 1'b1;
              state   <= DONE;
            end
          end
        end
        BUS: begin
          // Ack is checked before the terminal count so a last-cycle ack wins.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              Data       <= bus_rdata;
              data_valid <= 1'b1;
            end
            state <= DONE;
          end else if (wait_tc) begin
            bus_req <= 1'b0;
            mem_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_R_EN, Mem_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic        freeze;
  logic [31:0] Data;
  logic        data_valid, mem_err;
  logic        bus_req, bus_we;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // observations from the last run_access
  int          n_freeze, n_req, done_cyc, dv_cyc, dv_cnt, err_cyc, err_cnt;
  logic        stable, req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata, data_at_done;

  mem_access_ctrl #(
    .BASE_ADDR (32'd1024),
    .DEPTH     (64),
    .AW        (6),
    .TIMEOUT   (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Mem_R_EN   (Mem_R_EN),
    .Mem_W_EN   (Mem_W_EN),
    .ALU_Res    (ALU_Res),
    .Val_Rm     (Val_Rm),
    .freeze     (freeze),
    .Data       (Data),
    .data_valid (data_valid),
    .mem_err    (mem_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in cycle 0 (caller is just after a rising edge), acks in
  // cycle ack_cyc (negative = never) and records what the DUT did until the
  // first cycle after cycle 0 with freeze low, then drops the op.
  task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_cyc, input logic [31:0] rdata);
    Mem_R_EN = r; Mem_W_EN = w; ALU_Res = addr; Val_Rm = wd;
    n_freeze = 0; n_req = 0; done_cyc = -1; dv_cyc = -1; dv_cnt = 0;
    err_cyc = -1; err_cnt = 0; stable = 1'b1;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; data_at_done = '0;
    for (int c = 0; c < 40; c++) begin
      bus_ack   = (c == ack_cyc);
      bus_rdata = (c == ack_cyc) ? rdata : 32'h0BAD0BAD;
      @(negedge clk);
      if (freeze) n_freeze++;
      if (bus_req) begin
        if (n_req == 0) begin
          req_addr = bus_addr; req_we = bus_we; req_wdata = bus_wdata;
        end else if (bus_addr !== req_addr || bus_we !== req_we || bus_wdata !== req_wdata) begin
          stable = 1'b0;
        end
        n_req++;
      end
      if (data_valid) begin dv_cnt++; dv_cyc = c; end
      if (mem_err) begin err_cnt++; err_cyc = c; end
      if (c > 0 && !freeze) begin
        done_cyc = c;
        data_at_done = Data;
        break;
      end
      tick();
    end
    tick();
    Mem_R_EN = 1'b0; Mem_W_EN = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Mem_R_EN = 0; Mem_W_EN = 0; ALU_Res = 0; Val_Rm = 0;
    bus_ack = 0; bus_rdata = 0;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (freeze !== 1'b0) $display("FAIL reset_freeze: got %b expected 0", freeze); else n_pass++;
    n_checks++; if (Data !== 32'd0) $display("FAIL reset_data: got %h expected 0", Data); else n_pass++;
    n_checks++; if ({data_valid, mem_err, bus_req, bus_we} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {data_valid, mem_err, bus_req, bus_we}); else n_pass++;
    n_checks++; if (bus_addr !== 6'd0 || bus_wdata !== 32'd0)
      $display("FAIL reset_bus: got addr %0d wdata %h expected 0 0", bus_addr, bus_wdata); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'd1064, 32'd0, 1, 32'd10);
    n_checks++; if (req_addr !== 6'd10 || req_we !== 1'b0)
      $display("FAIL load_bus: got addr %0d we %b expected 10 0", req_addr, req_we); else n_pass++;
    n_checks++; if (n_req !== 1) $display("FAIL load_req_cycles: got %0d expected 1", n_req); else n_pass++;
    n_checks++; if (dv_cyc !== 2 || dv_cnt !== 1)
      $display("FAIL load_valid: got cycle %0d count %0d expected 2 1", dv_cyc, dv_cnt); else n_pass++;
    n_checks++; if (data_at_done !== 32'd10) $display("FAIL load_data: got %h expected 0000000a", data_at_done); else n_pass++;
    n_checks++; if (n_freeze !== 2 || done_cyc !== 2)
      $display("FAIL load_freeze: got %0d cycles, done %0d expected 2 2", n_freeze, done_cyc); else n_pass++;
  endtask

  task automatic test_store_reload();
    run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 3, 32'h12345678);
    n_checks++; if (n_freeze !== 4 || done_cyc !== 4)
      $display("FAIL store_freeze: got %0d cycles, done %0d expected 4 4", n_freeze, done_cyc); else n_pass++;
    n_checks++; if (n_req !== 3 || !stable || req_wdata !== 32'hDEADBEEF || req_we !== 1'b1 || req_addr !== 6'd1)
      $display("FAIL store_bus: got req %0d stable %b wdata %h we %b addr %0d expected 3 1 deadbeef 1 1",
               n_req, stable, req_wdata, req_we, req_addr); else n_pass++;
    n_checks++; if (dv_cnt !== 0 || err_cnt !== 0 || data_at_done !== 32'd10)
      $display("FAIL store_data_kept: got dv %0d err %0d data %h expected 0 0 0000000a",
               dv_cnt, err_cnt, data_at_done); else n_pass++;
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, 2, 32'hDEADBEEF);
    n_checks++; if (data_at_done !== 32'hDEADBEEF || dv_cyc !== 3)
      $display("FAIL reload_data: got %h at %0d expected deadbeef at 3", data_at_done, dv_cyc); else n_pass++;
  endtask

  task automatic test_boundary();
    run_access(1'b1, 1'b0, 32'd1276, 32'd0, 1, 32'h00000063);
    n_checks++; if (req_addr !== 6'd63 || err_cnt !== 0 || data_at_done !== 32'h63)
      $display("FAIL last_word: got addr %0d err %0d data %h expected 63 0 00000063",
               req_addr, err_cnt, data_at_done); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [4];
    logic [1:0]  rw    [4];
    addrs = '{32'd1026, 32'd1280, 32'd1000, 32'd1064};
    rw    = '{2'b10,    2'b10,    2'b01,    2'b11};
    for (int i = 0; i < 4; i++) begin
      run_access(rw[i][1], rw[i][0], addrs[i], 32'h55AA55AA, 1, 32'hFFFFFFFF);
      n_checks++; if (err_cyc !== 1 || err_cnt !== 1 || done_cyc !== 1 || n_freeze !== 1)
        $display("FAIL illegal_%0d: got err cyc %0d cnt %0d done %0d freeze %0d expected 1 1 1 1",
                 i, err_cyc, err_cnt, done_cyc, n_freeze); else n_pass++;
      n_checks++; if (n_req !== 0 || dv_cnt !== 0 || data_at_done !== 32'h63)
        $display("FAIL illegal_nobus_%0d: got req %0d dv %0d data %h expected 0 0 00000063",
                 i, n_req, dv_cnt, data_at_done); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'd1064, 32'd0, -1, 32'd0);
    n_checks++; if (n_req !== 15) $display("FAIL timeout_req_cycles: got %0d expected 15", n_req); else n_pass++;
    n_checks++; if (err_cyc !== 16 || err_cnt !== 1 || done_cyc !== 16 || n_freeze !== 16)
      $display("FAIL timeout_err: got err %0d cnt %0d done %0d freeze %0d expected 16 1 16 16",
               err_cyc, err_cnt, done_cyc, n_freeze); else n_pass++;
    n_checks++; if (dv_cnt !== 0 || data_at_done !== 32'h63)
      $display("FAIL timeout_data: got dv %0d data %h expected 0 00000063", dv_cnt, data_at_done); else n_pass++;
  endtask

  task automatic test_ack_at_limit();
    run_access(1'b1, 1'b0, 32'd1068, 32'd0, 15, 32'hA5A5_0F0F);
    n_checks++; if (err_cnt !== 0 || dv_cyc !== 16 || data_at_done !== 32'hA5A50F0F || n_req !== 15)
      $display("FAIL ack_at_limit: got err %0d dv %0d data %h req %0d expected 0 16 a5a50f0f 15",
               err_cnt, dv_cyc, data_at_done, n_req); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'd1032, 32'h01020304, 1, 32'd0);
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1, 32'h01020304);
    n_checks++; if (done_cyc !== 2 || data_at_done !== 32'h01020304 || req_addr !== 6'd2)
      $display("FAIL back_to_back: got done %0d data %h addr %0d expected 2 01020304 2",
               done_cyc, data_at_done, req_addr); else n_pass++;
  endtask

  task automatic test_rst_mid();
    Mem_R_EN = 1'b1; ALU_Res = 32'd1064; bus_ack = 1'b0; bus_rdata = 32'd0;
    tick();                       // cycle 1: BUS
    tick();                       // cycle 2
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b1) $display("FAIL rst_pre_req: got %b expected 1", bus_req); else n_pass++;
    rst = 1'b1; Mem_R_EN = 1'b0;  // reset applied during cycle 2
    tick();                       // cycle 3
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({freeze, data_valid, mem_err, bus_req, bus_we} !== 5'b0 || Data !== 32'd0 || bus_addr !== 6'd0 || bus_wdata !== 32'd0)
      $display("FAIL rst_mid_outputs: got ctl %b data %h addr %0d wdata %h expected 00000 0 0 0",
               {freeze, data_valid, mem_err, bus_req, bus_we}, Data, bus_addr, bus_wdata); else n_pass++;
    tick();                       // cycle 4: late ack
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();                       // cycle 5
    bus_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (data_valid !== 1'b0 || Data !== 32'd0 || mem_err !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL rst_late_ack: got dv %b data %h err %b req %b expected 0 0 0 0",
               data_valid, Data, mem_err, bus_req); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_reload();
    test_boundary();
    test_illegal();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
